rope_engine: RTL and testbench

Parametrised rope/claw motion engine for the Gold Miner playfield. Swings the rope about a configurable origin, fires on a key press, extends until it reaches a wall/length limit or an item, then retracts at a weight-dependent speed and reports the delivered item. Sits between the keyboard/KEY debouncer and the renderer and item manager; one instance per player.

---
 rtl/gm_pkg.sv | 30 +++
 rtl/rope_trig_lut.sv | 49 ++++
 rtl/rope_engine.sv | 161 ++++++++++++++++
 tb/tb_rope_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | gm_pkg: shared Gold Miner types, screen bounds and fixed-point width. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gm_pkg;

  typedef enum logic [2:0] {
    SWING_CCW = 3'd0,
    SWING_CW  = 3'd1,
    EXTEND    = 3'd2,
    RETRACT   = 3'd3,
    DELIVER   = 3'd4
  } rope_state_t;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FRAC_W   = 7;

  // Heavier items pull back slower, but the rope always moves at least 1 px.
  function automatic logic [9:0] retract_step(input logic [9:0] speed,
                                              input logic [1:0] weight);
    logic [9:0] s;
    s = speed >> weight;
    return (s == 10'd0) ? 10'd1 : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rope_trig_lut.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rope_trig_lut: 0..180 degree sin/cos ROM, signed Q1.7 outputs.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rope_trig_lut (
  input  logic [7:0]        degree,
  output logic signed [7:0] sin_q,
  output logic signed [7:0] cos_q
);

  // Quarter-wave magnitude round(128*sin(a)); full scale saturates to 127.
  localparam logic [6:0] QTAB [0:90] = '{
    7'd0,   7'd2,   7'd4,   7'd7,   7'd9,   7'd11,  7'd13,  7'd16,  7'd18,  7'd20,
    7'd22,  7'd24,  7'd27,  7'd29,  7'd31,  7'd33,  7'd35,  7'd37,  7'd40,  7'd42,
    7'd44,  7'd46,  7'd48,  7'd50,  7'd52,  7'd54,  7'd56,  7'd58,  7'd60,  7'd62,
    7'd64,  7'd66,  7'd68,  7'd70,  7'd72,  7'd73,  7'd75,  7'd77,  7'd79,  7'd81,
    7'd82,  7'd84,  7'd86,  7'd87,  7'd89,  7'd91,  7'd92,  7'd94,  7'd95,  7'd97,
    7'd98,  7'd99,  7'd101, 7'd102, 7'd104, 7'd105, 7'd106, 7'd107, 7'd109, 7'd110,
    7'd111, 7'd112, 7'd113, 7'd114, 7'd115, 7'd116, 7'd117, 7'd118, 7'd119, 7'd119,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd124, 7'd125, 7'd125, 7'd126,
    7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  logic [7:0] deg_c;
  logic [6:0] sin_idx;
  logic [6:0] cos_idx;
  logic [6:0] sin_mag;
  logic [6:0] cos_mag;

  always_comb begin
    deg_c = (degree > 8'd180) ? 8'd180 : degree;
    if (deg_c <= 8'd90) begin
      sin_idx = deg_c[6:0];
      cos_idx = 7'(8'd90 - deg_c);
    end else begin
      sin_idx = 7'(8'd180 - deg_c);
      cos_idx = 7'(deg_c - 8'd90);
    end
    sin_mag = QTAB[sin_idx];
    cos_mag = QTAB[cos_idx];
    sin_q   = $signed({1'b0, sin_mag});
    cos_q   = (deg_c > 8'd90) ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
  end

endmodule
`default_nettype wire

// File: rtl/rope_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | rope_engine: swing/extend/retract rope FSM with registered tip math. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rope_engine #(
  parameter int ORIGIN_X  = 160,
  parameter int ORIGIN_Y  = 45,
  parameter int LEN_MIN   = 12,
  parameter int LEN_MAX   = 200,
  parameter int DEG_MIN   = 10,
  parameter int DEG_MAX   = 170,
  parameter int EXT_SPEED = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       tick,
  input  logic       fire_key,
  input  logic       hit,
  input  logic [1:0] hit_weight,
  output logic [2:0] state,
  output logic [7:0] degree,
  output logic [9:0] rope_len,
  output logic [9:0] endX,
  output logic [9:0] endY,
  output logic       grabbed,
  output logic       delivered
);

  import gm_pkg::*;

  localparam logic [9:0]        L_MIN = 10'(LEN_MIN);
  localparam logic [9:0]        L_MAX = 10'(LEN_MAX);
  localparam logic [7:0]        D_MIN = 8'(DEG_MIN);
  localparam logic [7:0]        D_MAX = 8'(DEG_MAX);
  localparam logic [9:0]        SPEED = 10'(EXT_SPEED);
  localparam logic signed [18:0] OX   = 19'(ORIGIN_X);
  localparam logic signed [18:0] OY   = 19'(ORIGIN_Y);
  localparam logic signed [18:0] X_HI = 19'(SCREEN_W - 1);
  localparam logic signed [18:0] Y_HI = 19'(SCREEN_H - 1);

  rope_state_t st;
  logic [1:0]  weight;
  logic        fire_prev;
  logic        off_screen;
  logic        fire_rise;
  logic [9:0]  step_len;

  logic signed [7:0]  sin_q;
  logic signed [7:0]  cos_q;
  logic signed [17:0] prod_x;
  logic signed [17:0] prod_y;
  logic signed [18:0] sum_x;
  logic signed [18:0] sum_y;
  logic [9:0]         clamp_x;
  logic [9:0]         clamp_y;
  logic               oob;

  rope_trig_lut u_lut (
    .degree (degree),
    .sin_q  (sin_q),
    .cos_q  (cos_q)
  );

  assign state     = st;
  assign fire_rise = fire_key & ~fire_prev;
  assign step_len  = retract_step(SPEED, grabbed ? weight : 2'd0);

  // Wall detection uses the unclamped sums so a tip past x=0 is still seen.
  always_comb begin
    prod_x = $signed({8'd0, rope_len}) * $signed({{10{cos_q[7]}}, cos_q});
    prod_y = $signed({8'd0, rope_len}) * $signed({{10{sin_q[7]}}, sin_q});
    sum_x  = OX + ($signed({prod_x[17], prod_x}) >>> FRAC_W);
    sum_y  = OY + ($signed({prod_y[17], prod_y}) >>> FRAC_W);
    if (sum_x < 19'sd0)         clamp_x = 10'd0;
    else if (sum_x > 19'sd1023) clamp_x = 10'd1023;
    else                        clamp_x = sum_x[9:0];
    if (sum_y < 19'sd0)         clamp_y = 10'd0;
    else if (sum_y > 19'sd1023) clamp_y = 10'd1023;
    else                        clamp_y = sum_y[9:0];
    oob = (sum_x < 19'sd0) || (sum_x > X_HI) || (sum_y < 19'sd0) || (sum_y > Y_HI);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st         <= SWING_CCW;
      degree     <= 8'd90;
      rope_len   <= L_MIN;
      endX       <= 10'(ORIGIN_X);
      endY       <= 10'(ORIGIN_Y + LEN_MIN);
      off_screen <= 1'b0;
      grabbed    <= 1'b0;
      delivered  <= 1'b0;
      weight     <= 2'd0;
      fire_prev  <= 1'b0;
    end else begin
      fire_prev <= fire_key;
      if (enable) begin
        endX       <= clamp_x;
        endY       <= clamp_y;
        off_screen <= oob;
        unique case (st)
          SWING_CCW: begin
            if (fire_rise) begin
              st <= EXTEND;
            end else if (tick) begin
              if (degree >= D_MAX - 8'd1) begin
                degree <= D_MAX;
                st     <= SWING_CW;
              end else begin
                degree <= degree + 8'd1;
              end
            end
          end
          SWING_CW: begin
            if (fire_rise) begin
              st <= EXTEND;
            end else if (tick) begin
              if (degree <= D_MIN + 8'd1) begin
                degree <= D_MIN;
                st     <= SWING_CCW;
              end else begin
                degree <= degree - 8'd1;
              end
            end
          end
          EXTEND: begin
            if (hit) begin
              weight  <= hit_weight;
              grabbed <= 1'b1;
              st      <= RETRACT;
            end else if (rope_len >= L_MAX || off_screen) begin
              st <= RETRACT;
            end else if (tick) begin
              rope_len <= (rope_len >= L_MAX - SPEED) ? L_MAX : rope_len + SPEED;
            end
          end
          RETRACT: begin
            if (rope_len <= L_MIN) begin
              st        <= grabbed ? DELIVER : SWING_CCW;
              delivered <= grabbed;
            end else if (tick) begin
              rope_len <= (rope_len <= L_MIN + step_len) ? L_MIN : rope_len - step_len;
            end
          end
          DELIVER: begin
            delivered <= 1'b0;
            grabbed   <= 1'b0;
            weight    <= 2'd0;
            st        <= SWING_CCW;
          end
          default: st <= SWING_CCW;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rope_engine.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rope_engine: directed table and sequence bench for rope_engine.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rope_engine;

  localparam real PI = 3.14159265358979;
  localparam int  S_CCW = 0, S_CW = 1, S_EXT = 2, S_RET = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       tick = 1'b0;
  logic       fire_key = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] hit_weight = 2'd0;
  logic [2:0] state;
  logic [7:0] degree;
  logic [9:0] rope_len;
  logic [9:0] endX;
  logic [9:0] endY;
  logic       grabbed;
  logic       delivered;

  int n_checks = 0;
  int n_errors = 0;
  int deliv_cycles = 0;

  rope_engine dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .tick       (tick),
    .fire_key   (fire_key),
    .hit        (hit),
    .hit_weight (hit_weight),
    .state      (state),
    .degree     (degree),
    .rope_len   (rope_len),
    .endX       (endX),
    .endY       (endY),
    .grabbed    (grabbed),
    .delivered  (delivered)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (resetn && delivered) deliv_cycles++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int n_ticks;
    int exp_deg;
    int exp_state;
  } swing_vec_t;

  function automatic int qtrig(input int d, input bit is_cos);
    real r;
    int  v;
    r = is_cos ? $cos(d * PI / 180.0) : $sin(d * PI / 180.0);
    r = r * 128.0;
    v = (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    if (v > 127)  v = 127;
    if (v < -127) v = -127;
    return v;
  endfunction

  function automatic int tip(input int origin, input int len, input int f);
    int s;
    s = origin + ((len * f) >>> 7);
    if (s < 0)    s = 0;
    if (s > 1023) s = 1023;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; tick = 1'b0; fire_key = 1'b0; hit = 1'b0; hit_weight = 2'd0;
    step();
    step();
    resetn = 1'b1;
    enable = 1'b1;
    step();
  endtask

  task automatic fire();
    fire_key = 1'b1;
    step();
    fire_key = 1'b0;
    step();
  endtask

  swing_vec_t vecs [9];
  int exp_len;
  int guard;
  int held_len;

  initial begin
    vecs[0] = '{0,  90,  S_CCW};
    vecs[1] = '{10, 100, S_CCW};
    vecs[2] = '{69, 169, S_CCW};
    vecs[3] = '{1,  170, S_CW};
    vecs[4] = '{1,  169, S_CW};
    vecs[5] = '{79, 90,  S_CW};
    vecs[6] = '{79, 11,  S_CW};
    vecs[7] = '{1,  10,  S_CCW};
    vecs[8] = '{1,  11,  S_CCW};

    // Reset values, observed while reset is still held.
    #12;
    check("rst_state", int'(state), S_CCW);
    check("rst_degree", int'(degree), 90);
    check("rst_len", int'(rope_len), 12);
    check("rst_endX", int'(endX), 160);
    check("rst_endY", int'(endY), 57);
    check("rst_grabbed", int'(grabbed), 0);
    check("rst_delivered", int'(delivered), 0);

    // Swing table: cumulative ticks from reset, tip compared to a trig model.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int t = 0; t < vecs[i].n_ticks; t++) begin
        tick = 1'b1;
        step();
      end
      tick = 1'b0;
      step();
      step();
      check($sformatf("swing%0d_degree", i), int'(degree), vecs[i].exp_deg);
      check($sformatf("swing%0d_state", i), int'(state), vecs[i].exp_state);
      check($sformatf("swing%0d_len", i), int'(rope_len), 12);
      check($sformatf("swing%0d_endX", i), int'(endX), tip(160, 12, qtrig(vecs[i].exp_deg, 1'b1)));
      check($sformatf("swing%0d_endY", i), int'(endY), tip(45, 12, qtrig(vecs[i].exp_deg, 1'b0)));
    end

    // Fire at 90 degrees, no hit: full extension then empty retract.
    do_reset();
    deliv_cycles = 0;
    fire();
    check("a_extend", int'(state), S_EXT);
    exp_len = 12;
    guard = 0;
    while (state == 3'(S_EXT) && guard < 100) begin
      do_tick();
      exp_len = (exp_len + 4 > 200) ? 200 : exp_len + 4;
      check("a_ext_len", int'(rope_len), exp_len);
      guard++;
    end
    check("a_peak_len", exp_len, 200);
    check("a_retract", int'(state), S_RET);
    check("a_grabbed", int'(grabbed), 0);
    guard = 0;
    while (state == 3'(S_RET) && guard < 100) begin
      do_tick();
      exp_len = (exp_len - 4 < 12) ? 12 : exp_len - 4;
      check("a_ret_len", int'(rope_len), exp_len);
      guard++;
    end
    check("a_end_state", int'(state), S_CCW);
    check("a_end_degree", int'(degree), 90);
    check("a_no_deliver", deliv_cycles, 0);

    // Hit weight 2 at length 60: retract by 1 per tick, one delivered pulse.
    do_reset();
    deliv_cycles = 0;
    fire();
    for (int t = 0; t < 12; t++) do_tick();
    check("b_len60", int'(rope_len), 60);
    hit = 1'b1;
    hit_weight = 2'd2;
    step();
    hit = 1'b0;
    hit_weight = 2'd0;
    check("b_state", int'(state), S_RET);
    check("b_grabbed", int'(grabbed), 1);
    exp_len = 60;
    guard = 0;
    while (state == 3'(S_RET) && guard < 100) begin
      do_tick();
      exp_len = (exp_len - 1 < 12) ? 12 : exp_len - 1;
      check("b_ret_len", int'(rope_len), exp_len);
      guard++;
    end
    check("b_ret_ticks", guard, 48);
    check("b_deliv_cycles", deliv_cycles, 1);
    check("b_end_state", int'(state), S_CCW);
    check("b_end_grabbed", int'(grabbed), 0);

    // Fire at 10 degrees: right wall reached before LEN_MAX.
    do_reset();
    tick = 1'b1;
    for (int t = 0; t < 240; t++) step();
    tick = 1'b0;
    step();
    check("c_degree", int'(degree), 10);
    fire();
    guard = 0;
    while (state == 3'(S_EXT) && guard < 100) begin
      do_tick();
      guard++;
    end
    check("c_state", int'(state), S_RET);
    check("c_grabbed", int'(grabbed), 0);
    check("c_exit_len", int'(rope_len), 164);
    check("c_endX", int'(endX), tip(160, 164, qtrig(10, 1'b1)));

    // Hit arriving in the same cycle the LEN_MAX limit is seen: hit wins.
    do_reset();
    fire();
    for (int t = 0; t < 46; t++) do_tick();
    check("d_len196", int'(rope_len), 196);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("d_len200", int'(rope_len), 200);
    check("d_still_ext", int'(state), S_EXT);
    hit = 1'b1;
    hit_weight = 2'd3;
    step();
    hit = 1'b0;
    hit_weight = 2'd0;
    check("d_state", int'(state), S_RET);
    check("d_grabbed", int'(grabbed), 1);
    do_tick();
    check("d_heavy_step", int'(rope_len), 199);

    // Key held across re-enable must not fire; ticks ignored while disabled.
    do_reset();
    enable = 1'b0;
    fire_key = 1'b1;
    do_tick();
    do_tick();
    check("e_dis_degree", int'(degree), 90);
    enable = 1'b1;
    step();
    step();
    check("e_no_fire", int'(state), S_CCW);
    fire_key = 1'b0;
    step();
    fire();
    check("e_fire", int'(state), S_EXT);

    // Disable mid-EXTEND for 10 ticks, then resume.
    for (int t = 0; t < 5; t++) do_tick();
    held_len = int'(rope_len);
    check("f_len32", held_len, 32);
    enable = 1'b0;
    for (int t = 0; t < 10; t++) do_tick();
    check("f_frozen_len", int'(rope_len), held_len);
    check("f_frozen_state", int'(state), S_EXT);
    enable = 1'b1;
    do_tick();
    check("f_resume_len", int'(rope_len), held_len + 4);

    // Asynchronous reset during RETRACT.
    hit = 1'b1;
    step();
    hit = 1'b0;
    do_tick();
    check("g_retract", int'(state), S_RET);
    #2;
    resetn = 1'b0;
    #1;
    check("g_rst_state", int'(state), S_CCW);
    check("g_rst_degree", int'(degree), 90);
    check("g_rst_len", int'(rope_len), 12);
    check("g_rst_grabbed", int'(grabbed), 0);
    step();
    resetn = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
